// File: rtl/fetch_queue.sv
// Instruction fetch queue: DEPTH-entry circular buffer of {pc, inst} between i-cache and decode.
// Define FETCH_QUEUE_BYPASS_EN to let an instruction reach decode combinationally when the queue is empty.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        out_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          empty;
  logic          push;
  logic          pop;

  assign empty    = (count == '0);
  assign in_ready = (count != CW'(DEPTH));

  always_comb begin
    out_valid = !empty;
    out_pc    = empty ? 32'd0 : pc_mem[rd_ptr];
    out_inst  = empty ? 32'd0 : inst_mem[rd_ptr];
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush && !empty;
`ifdef FETCH_QUEUE_BYPASS_EN
    // An empty queue hands the incoming instruction straight to decode; it is stored only if decode stalls.
    if (empty) begin
      out_valid = in_valid && !flush;
      out_pc    = in_pc;
      out_inst  = in_inst;
      push      = in_valid && !flush && !out_ready;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule
